dual_port_ram_stream_writer: RTL

- Write-side counterpart to the team's inferred dual-port ROMs.
- Contains an inferred simple dual-port RAM. Port A is written by a sequencing engine that accepts a valid/ready word stream. Port B is a synchronous read port with the same 1-cycle registered timing as the ROM.
- Used to load tables at run time and, on request, clear the whole memory first.

---
 rtl/dual_port_ram_stream_writer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_stream_writer.sv
// rtl/dual_port_ram_stream_writer.sv - stream-loaded simple dual-port RAM with optional clear pass and registered read port
module dual_port_ram_stream_writer #(
    parameter int                  DATA_WIDTH  = 12,
    parameter int                  ADDR_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear_en,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
    localparam logic [ADDR_WIDTH:0]   ONE_W = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic                  fire;
    logic                  last_word;
    logic                  clr_last;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    // A transfer completes the job when it brings the word count up to the latched length
    assign fire      = s_valid && (state == LOAD);
    assign last_word = (word_cnt + ONE_W) == len_q;
    assign clr_last  = (clr_cnt == '1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE so requests while busy are dropped
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (clear_en) begin
                        state_next = CLEAR;
                    end else if (length != '0) begin
                        state_next = LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_next = (len_q != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (fire && last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs and the single port-A write strobe, all decoded from the current state
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        we      = 1'b0;
        waddr   = wr_addr;
        wdata   = s_data;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_cnt;
                wdata = CLEAR_VALUE;
            end
            LOAD: begin
                s_ready = 1'b1;
                we      = s_valid;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Job bookkeeping: parameters latched at start, counters advanced by clear and load progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            word_cnt <= '0;
            wr_addr  <= '0;
            clr_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= length;
                        wr_addr  <= base_addr;
                        word_cnt <= '0;
                        clr_cnt  <= '0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + ONE_A;
                end
                LOAD: begin
                    if (fire) begin
                        wr_addr  <= wr_addr + ONE_A;
                        word_cnt <= word_cnt + ONE_W;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Port A write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Port B registered read; a same-cycle write to the same address returns the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
